// File: rtl/alu_pkg.sv
// Shared types for the ALU operand sequencer.
//   opcode_t : ALU operation encoding driven on opcode
//   state_t  : sequencer FSM states, exported on the state LEDs
//   FLAG_*   : bit positions inside the 4-bit {N,Z,C,V} flag bus
package alu_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned OPCODE_W = 2;
    localparam int unsigned FLAGS_W  = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [OPCODE_W-1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        OR  = 2'b10,
        AND = 2'b11
    } opcode_t;

    typedef enum logic [STATE_W-1:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already-synchronised level.
//   clk, reset : clock and async active-high reset
//   level      : input level
//   rise       : combinational one-cycle pulse on a 0->1 transition
// The history flop resets to 1 so a level held high across reset release
// produces no edge.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    // Previous-cycle level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps a button/switch front panel through operand A, operand B and opcode
// entry, then captures one ALU result for display.
//   clk, reset         : clock, async active-high reset
//   data_in, enter     : switch value and synchronised button level
//   clear              : synchronous abort to WAIT_A, zeroing all outputs
//   op_a, op_b, opcode : registered ALU operands / operation
//   alu_result/flags   : combinational ALU outputs ({N,Z,C,V})
//   result, flags      : captured ALU outputs
//   result_valid       : high while a captured result is shown
//   state              : current FSM encoding for the LEDs
// Optional feature: define ALU_ACCUMULATE_EN to make an edge in SHOW load
// the shown result into op_a and resume at WAIT_B (chained operation).
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W-1:0]        data_in,
    input  logic                enter,
    input  logic                clear,
    output logic [W-1:0]        op_a,
    output logic [W-1:0]        op_b,
    output logic [OPCODE_W-1:0] opcode,
    input  logic [W-1:0]        alu_result,
    input  logic [FLAGS_W-1:0]  alu_flags,
    output logic [W-1:0]        result,
    output logic [FLAGS_W-1:0]  flags,
    output logic                result_valid,
    output logic [STATE_W-1:0]  state
);

    state_t               state_q, state_d;
    logic [W-1:0]         op_a_d, op_b_d, result_d;
    logic [OPCODE_W-1:0]  opcode_d;
    logic [FLAGS_W-1:0]   flags_d;
    logic                 result_valid_d;
    logic                 rise;

    // Upper switch bits are don't-care when entering the opcode
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[W-1:OPCODE_W];

    edge_detect u_enter_edge (
        .clk   (clk),
        .reset (reset),
        .level (enter),
        .rise  (rise)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_A;
            op_a         <= '0;
            op_b         <= '0;
            opcode       <= '0;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a         <= op_a_d;
            op_b         <= op_b_d;
            opcode       <= opcode_d;
            result       <= result_d;
            flags        <= flags_d;
            result_valid <= result_valid_d;
        end
    end

    // Next-state and capture logic; clear overrides any simultaneous edge
    always_comb begin
        state_d        = state_q;
        op_a_d         = op_a;
        op_b_d         = op_b;
        opcode_d       = opcode;
        result_d       = result;
        flags_d        = flags;
        result_valid_d = result_valid;

        if (clear) begin
            state_d        = WAIT_A;
            op_a_d         = '0;
            op_b_d         = '0;
            opcode_d       = '0;
            result_d       = '0;
            flags_d        = '0;
            result_valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (rise) begin
                        op_a_d  = data_in;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rise) begin
                        op_b_d  = data_in;
                        state_d = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (rise) begin
                        opcode_d = data_in[OPCODE_W-1:0];
                        state_d  = EXEC;
                    end
                end
                // Single cycle, edges here are dropped rather than queued
                EXEC: begin
                    result_d       = alu_result;
                    flags_d        = alu_flags;
                    result_valid_d = 1'b1;
                    state_d        = SHOW;
                end
                SHOW: begin
                    if (rise) begin
                        result_valid_d = 1'b0;
`ifdef ALU_ACCUMULATE_EN
                        op_a_d  = result;
                        state_d = WAIT_B;
`else
                        state_d = WAIT_A;
`endif
                    end
                end
                default: begin
                    state_d = WAIT_A;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural ALU attached.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_operand_sequencer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         enter;
    logic         clear;
    logic [W-1:0] op_a, op_b, result;
    logic [1:0]   opcode;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags, flags;
    logic         result_valid;
    logic [2:0]   state;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .enter        (enter),
        .clear        (clear),
        .op_a         (op_a),
        .op_b         (op_b),
        .opcode       (opcode),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .result       (result),
        .flags        (flags),
        .result_valid (result_valid),
        .state        (state)
    );

    // Behavioural ALU: flags {N,Z,C,V}; SUB carry means no borrow
    logic [W:0] alu_wide;
    logic       alu_v;
    always_comb begin
        alu_wide = '0;
        alu_v    = 1'b0;
        case (opcode)
            2'b00: begin
                alu_wide = {1'b0, op_a} + {1'b0, op_b};
                alu_v    = (op_a[W-1] == op_b[W-1]) && (alu_wide[W-1] != op_a[W-1]);
            end
            2'b01: begin
                alu_wide = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
                alu_v    = (op_a[W-1] != op_b[W-1]) && (alu_wide[W-1] != op_a[W-1]);
            end
            2'b10:   alu_wide = {1'b0, op_a | op_b};
            default: alu_wide = {1'b0, op_a & op_b};
        endcase
        alu_result = alu_wide[W-1:0];
        alu_flags  = {alu_wide[W-1], (alu_wide[W-1:0] == '0), alu_wide[W], alu_v};
    end

    // One clean press: high for one cycle, low for one cycle
    task automatic press(input logic [W-1:0] v);
        data_in = v;
        enter   = 1'b1;
        @(negedge clk);
        enter   = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enter = 1'b0; clear = 1'b0; data_in = '0;
        #1;
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_cmp++; if ({op_a, op_b, opcode, result, flags, result_valid} !== '0) begin n_fail++;
            $display("FAIL reset_outputs got a=%h b=%h op=%b r=%h f=%b v=%b exp all 0", op_a, op_b, opcode, result, flags, result_valid); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sub_latency();
        press(8'h05);
        press(8'h03);
        n_cmp++; if (state !== 3'd2 || op_a !== 8'h05 || op_b !== 8'h03) begin n_fail++;
            $display("FAIL sub_operands got st=%0d a=%h b=%h exp st=2 a=05 b=03", state, op_a, op_b); end
        data_in = 8'h01; enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        n_cmp++; if (state !== 3'd3 || opcode !== 2'b01 || result_valid !== 1'b0) begin n_fail++;
            $display("FAIL sub_t1 got st=%0d op=%b v=%b exp st=3 op=01 v=0", state, opcode, result_valid); end
        @(negedge clk);
        n_cmp++; if (state !== 3'd4 || result_valid !== 1'b1) begin n_fail++;
            $display("FAIL sub_t2 got st=%0d v=%b exp st=4 v=1", state, result_valid); end
        n_cmp++; if (result !== 8'h02 || flags[2] !== 1'b0 || flags !== 4'b0010) begin n_fail++;
            $display("FAIL sub_result got r=%h f=%b exp r=02 f=0010", result, flags); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (state !== 3'd4 || result_valid !== 1'b1 || result !== 8'h02) begin n_fail++;
            $display("FAIL show_hold got st=%0d v=%b r=%h exp st=4 v=1 r=02", state, result_valid, result); end
        pulse_clear();
    endtask

    task automatic test_and_zero();
        press(8'h0F);
        press(8'hF0);
        press(8'h03);
        n_cmp++; if (state !== 3'd4 || opcode !== 2'b11 || result !== 8'h00 || flags !== 4'b0100) begin n_fail++;
            $display("FAIL and_zero got st=%0d op=%b r=%h f=%b exp st=4 op=11 r=00 f=0100", state, opcode, result, flags); end
        pulse_clear();
    endtask

    task automatic test_opcode_upper_ignored();
        press(8'h50);
        press(8'h0A);
        press(8'hFE);
        n_cmp++; if (opcode !== 2'b10 || result !== 8'h5A || flags !== 4'b0000) begin n_fail++;
            $display("FAIL or_upper got op=%b r=%h f=%b exp op=10 r=5a f=0000", opcode, result, flags); end
        pulse_clear();
    endtask

    task automatic test_held_enter();
        logic [2:0] prev;
        int         trans;
        prev = state; trans = 0;
        data_in = 8'h11; enter = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state !== prev) trans++;
            prev = state;
        end
        enter = 1'b0;
        n_cmp++; if (trans !== 1 || state !== 3'd1 || op_a !== 8'h11) begin n_fail++;
            $display("FAIL held_enter got trans=%0d st=%0d a=%h exp trans=1 st=1 a=11", trans, state, op_a); end
        @(negedge clk);
        pulse_clear();
    endtask

    task automatic test_clear_priority();
        press(8'h22);
        press(8'h33);
        data_in = 8'h01; enter = 1'b1; clear = 1'b1;
        @(negedge clk);
        enter = 1'b0; clear = 1'b0;
        n_cmp++; if (state !== 3'd0 || {op_a, op_b, opcode, result, flags, result_valid} !== '0) begin n_fail++;
            $display("FAIL clear_edge got st=%0d a=%h b=%h op=%b r=%h f=%b v=%b exp all 0", state, op_a, op_b, opcode, result, flags, result_valid); end
        @(negedge clk);
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL clear_stay got st=%0d exp=0", state); end
    endtask

    task automatic test_reset_in_exec();
        press(8'h44);
        press(8'h11);
        data_in = 8'h00; enter = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL pre_reset_exec got st=%0d exp=3", state); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (state !== 3'd0 || {op_a, op_b, opcode, result, flags, result_valid} !== '0) begin n_fail++;
            $display("FAIL async_reset got st=%0d a=%h b=%h op=%b r=%h f=%b v=%b exp all 0", state, op_a, op_b, opcode, result, flags, result_valid); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (state !== 3'd0 || op_a !== 8'h00) begin n_fail++;
            $display("FAIL held_through_reset got st=%0d a=%h exp st=0 a=00", state, op_a); end
        enter = 1'b0;
        @(negedge clk);
        press(8'h09);
        n_cmp++; if (state !== 3'd1 || op_a !== 8'h09) begin n_fail++;
            $display("FAIL after_reset_edge got st=%0d a=%h exp st=1 a=09", state, op_a); end
        pulse_clear();
    endtask

    task automatic test_show_exit();
        press(8'h05);
        press(8'h03);
        press(8'h00);
        n_cmp++; if (state !== 3'd4 || result !== 8'h08 || flags !== 4'b0000) begin n_fail++;
            $display("FAIL add_result got st=%0d r=%h f=%b exp st=4 r=08 f=0000", state, result, flags); end
        press(8'hAA);
`ifdef ALU_ACCUMULATE_EN
        n_cmp++; if (state !== 3'd1 || op_a !== 8'h08 || result_valid !== 1'b0) begin n_fail++;
            $display("FAIL show_exit got st=%0d a=%h v=%b exp st=1 a=08 v=0", state, op_a, result_valid); end
`else
        n_cmp++; if (state !== 3'd0 || op_a !== 8'h05 || result_valid !== 1'b0) begin n_fail++;
            $display("FAIL show_exit got st=%0d a=%h v=%b exp st=0 a=05 v=0", state, op_a, result_valid); end
`endif
        pulse_clear();
    endtask

    initial begin
        test_reset();
        test_sub_latency();
        test_and_zero();
        test_opcode_upper_ignored();
        test_held_enter();
        test_clear_priority();
        test_reset_in_exec();
        test_show_exit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 SHALL have parameter W, default 8, the operand/result width; it matches the ALU's NA/NB/NR.
REQ-002 SHALL have port clk  in  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_in  in  W  the switch value sampled at each enter.
REQ-005 SHALL have port enter  in  1  the button level, already synchronised to clk.
REQ-006 SHALL have port clear  in  1  a synchronous abort back to WAIT_A.
REQ-007 SHALL have ports op_a  out  W, op_b  out  W and opcode  out  2; they drive the ALU operands and operation.
REQ-008 SHALL have ports alu_result  in  W and alu_flags  in  4 {N,Z,C,V}; they are the combinational ALU outputs.
REQ-009 SHALL have ports result  out  W and flags  out  4; they are the registered ALU outputs.
REQ-010 SHALL have port result_valid  out  1, high while a captured result is displayed.
REQ-011 SHALL have port state  out  3, the current FSM state encoding for the LEDs.

Function
REQ-012 SHALL detect enter rising edges as enter & ~enter_q; a held button advances exactly one step.
REQ-013 SHALL implement the FSM states WAIT_A, WAIT_B, WAIT_OP, EXEC and SHOW.
REQ-014 WAIT_A + edge: op_a<=data_in, go to WAIT_B.
REQ-015 WAIT_B + edge: op_b<=data_in, go to WAIT_OP.
REQ-016 WAIT_OP + edge: opcode<=data_in[1:0], go to EXEC; data_in[W-1:2] is ignored.
REQ-017 EXEC lasts exactly one cycle with no edge needed: result<=alu_result, flags<=alu_flags, go to SHOW.
REQ-018 Latency: with the WAIT_OP edge at cycle t, result_valid SHALL be high from cycle t+2.
REQ-019 SHOW SHALL hold result_valid=1, result and flags stable until the next edge, which clears result_valid and moves to WAIT_A (see REQ-027).
REQ-020 op_a, op_b and opcode SHALL hold their values in all states; they change only on their own capture.
REQ-021 Edges in EXEC SHALL be ignored, not queued.
REQ-022 clear=1 SHALL: go to WAIT_A; zero op_a, op_b, opcode, result, flags and result_valid; take priority over a simultaneous edge.
REQ-023 Unused state encodings SHALL recover to WAIT_A on the next clock.

Reset
REQ-024 reset=1 SHALL immediately force WAIT_A and zero op_a, op_b, opcode, result, flags and result_valid, independent of clk.
REQ-025 enter_q SHALL reset to 1, so a button held through reset release generates no edge.
REQ-026 Reset asserted mid-sequence (any state) SHALL discard all partial captures.

Configuration
REQ-027 With macro ALU_ACCUMULATE_EN defined, a SHOW edge SHALL load op_a<=result and go to WAIT_B (chained operation); without it, a SHOW edge goes to WAIT_A and op_a is unchanged.

Structure
REQ-028 SHALL use package alu_pkg holding: the opcode typedef (ADD=2'b00, SUB=2'b01, OR=2'b10, AND=2'b11); the state enum (WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW=4); and the flag bit indices N=3, Z=2, C=1, V=0.
REQ-029 SHALL place edge detection in sub-module edge_detect (clk, reset, level, rise).

Verification
REQ-030 With the bench's ALU instance connected: enter 0x05, 0x03, 0x01 -> opcode=01, result=0x02, Z=0, result_valid rising exactly 2 cycles after the third edge.
REQ-031 Enter 0x0F, 0xF0, 0x03 -> result=0x00, flags[Z]=1, N=0, C=0, V=0.
REQ-032 enter held high for 20 cycles in WAIT_A -> exactly one transition to WAIT_B.
REQ-033 clear asserted in WAIT_OP together with an enter edge -> state=WAIT_A, all outputs 0.
REQ-034 reset pulsed during EXEC while enter is held -> outputs 0 asynchronously; after release the state stays in WAIT_A until enter falls and rises again.
REQ-035 With ALU_ACCUMULATE_EN defined: 0x05+0x03 (result 0x08), then an edge in SHOW -> op_a=0x08, state=WAIT_B; without the macro -> state=WAIT_A, op_a=0x05.
